// File: rtl/pkt_tx_queue.sv
// Per-node packet FIFO between the packet generator and the packet TX of one NoC endpoint.
// First-word-fall-through with a registered head, valid and occupancy; drops on overflow.
package router_pkg;
  typedef struct packed {
    logic [7:0]  id;
    logic [3:0]  dst_x;
    logic [3:0]  dst_y;
    logic [15:0] payload;
  } pkt_t;
endpackage

module pkt_tx_queue #(
  parameter int X_ID  = 0,
  parameter int Y_ID  = 0,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  router_pkg::pkt_t         pkt_to_queue,
  input  logic                     pkt_rdy_to_queue,
  input  logic                     tx_ready,
  output router_pkg::pkt_t         pkt_to_tx,
  output logic                     pkt_to_tx_valid,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     overflow
);
  import router_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  if (X_ID < 0 || Y_ID < 0 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
    $error("pkt_tx_queue: bad parameters (node coordinates must be >= 0, DEPTH a power of two >= 2)");
  end

  pkt_t          mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [OW-1:0] occ_r;
  logic          valid_r;
  pkt_t          head_r;
  logic          ovf_r;

  logic          pop_s, push_ok_s, drop_s;
  logic [AW-1:0] wr_ptr_n_s, rd_ptr_n_s;
  logic [OW-1:0] occ_n_s;
  pkt_t          head_n_s;

  // Next-state: accept/drop decision, pointer and count updates, next head entry
  always_comb begin
    pop_s      = valid_r & tx_ready;
    push_ok_s  = 1'b0;
    drop_s     = 1'b0;
    if (pkt_rdy_to_queue) begin
      if ((occ_r < OW'(DEPTH)) || pop_s) begin
        push_ok_s = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      push_ok_s = 1'b0;
    end
    wr_ptr_n_s = wr_ptr_r + AW'(push_ok_s);
    rd_ptr_n_s = rd_ptr_r + AW'(pop_s);
    occ_n_s    = occ_r + OW'(push_ok_s) - OW'(pop_s);
    // The new head may be the very packet being written this cycle (queue empty, or
    // its last entry being popped); the array does not hold it until after the edge.
    if (push_ok_s && (wr_ptr_r == rd_ptr_n_s)) begin
      head_n_s = pkt_to_queue;
    end else begin
      head_n_s = mem_r[rd_ptr_n_s];
    end
  end

  // Storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= pkt_to_queue;
    end
  end

  // Control state and registered outputs
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      occ_r    <= '0;
      valid_r  <= 1'b0;
      head_r   <= '0;
      ovf_r    <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_n_s;
      rd_ptr_r <= rd_ptr_n_s;
      occ_r    <= occ_n_s;
      valid_r  <= (occ_n_s != OW'(0));
      head_r   <= head_n_s;
      ovf_r    <= ovf_r | drop_s;
    end
  end

  assign pkt_to_tx       = head_r;
  assign pkt_to_tx_valid = valid_r;
  assign occupancy       = occ_r;
  assign overflow        = ovf_r;

endmodule

// File: tb/tb_pkt_tx_queue.sv
// Self-checking bench for pkt_tx_queue: directed phases with random payloads,
// checked every cycle against a queue-based reference model.
module tb_pkt_tx_queue;
  localparam int DEPTH = 16;
  localparam int PW    = $bits(router_pkg::pkt_t);
  localparam int OW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic [PW-1:0] pkt_to_queue = '0;
  logic          pkt_rdy_to_queue = 1'b0;
  logic          tx_ready = 1'b0;
  logic [PW-1:0] pkt_to_tx;
  logic          pkt_to_tx_valid;
  logic [OW-1:0] occupancy;
  logic          overflow;

  pkt_tx_queue #(.X_ID(1), .Y_ID(2), .DEPTH(DEPTH)) dut (
    .clk(clk), .arst_n(arst_n),
    .pkt_to_queue(pkt_to_queue), .pkt_rdy_to_queue(pkt_rdy_to_queue),
    .tx_ready(tx_ready), .pkt_to_tx(pkt_to_tx), .pkt_to_tx_valid(pkt_to_tx_valid),
    .occupancy(occupancy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  logic [PW-1:0] q[$];
  bit            ovf_m;
  int            n_cmp, n_fail, n_popped;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk(input int id);
    logic [PW-9:0] r;
    r = (PW-8)'($urandom);
    return {8'(id), r};
  endfunction

  // One clock: drive inputs, let the model act on the pre-edge state, compare after the edge.
  task automatic cycle(input bit push, input logic [PW-1:0] d, input bit rdy);
    bit pop, acc;
    pkt_rdy_to_queue = push;
    pkt_to_queue     = d;
    tx_ready         = rdy;
    pop = (q.size() != 0) && rdy;
    acc = push && ((q.size() < DEPTH) || pop);
    @(posedge clk);
    #1;
    if (pop) begin
      void'(q.pop_front());
      n_popped++;
    end
    if (acc) q.push_back(d);
    else if (push) ovf_m = 1'b1;
    chk("valid", 32'(pkt_to_tx_valid), 32'(q.size() != 0));
    chk("occupancy", 32'(occupancy), 32'(q.size()));
    chk("overflow", 32'(overflow), 32'(ovf_m));
    if (q.size() != 0) chk("head", 32'(pkt_to_tx), 32'(q[0]));
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, rdy);
  endtask

  initial begin
    logic [PW-1:0] a, last;
    int base, sent, guard;
    n_cmp = 0; n_fail = 0; n_popped = 0; ovf_m = 1'b0;

    // Reset state
    #12;
    chk("rst_valid", 32'(pkt_to_tx_valid), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_head", 32'(pkt_to_tx), 32'd0);
    arst_n = 1'b1;
    @(posedge clk); #1;

    // Single packet held, then popped
    a = mk(8'hA0);
    cycle(1'b1, a, 1'b0);
    chk("t2_valid_next", 32'(pkt_to_tx_valid), 32'd1);
    chk("t2_head", 32'(pkt_to_tx), 32'(a));
    idle(10, 1'b0);
    chk("t2_held", 32'(pkt_to_tx), 32'(a));
    idle(1, 1'b1);
    chk("t2_empty", 32'(occupancy), 32'd0);

    // Ordering with tx_ready held high
    base = n_popped;
    for (int i = 1; i <= 5; i++) cycle(1'b1, mk(i), 1'b1);
    chk("t3_pops_during", 32'(n_popped - base), 32'd4);
    idle(3, 1'b1);
    chk("t3_pops", 32'(n_popped - base), 32'd5);

    // Fill past full, then drain
    for (int i = 1; i <= DEPTH + 1; i++) cycle(1'b1, mk(i), 1'b0);
    chk("t4_occ_full", 32'(occupancy), 32'(DEPTH));
    chk("t4_ovf", 32'(overflow), 32'd1);
    chk("t4_head_first", 32'(pkt_to_tx[PW-1 -: 8]), 32'd1);
    base = n_popped;
    idle(DEPTH + 2, 1'b1);
    chk("t4_drained", 32'(n_popped - base), 32'(DEPTH));

    // Asynchronous reset in the middle of traffic
    for (int i = 0; i < 3; i++) cycle(1'b1, mk(8'h50 + i), 1'b0);
    #2 arst_n = 1'b0;
    #1;
    chk("t1_valid", 32'(pkt_to_tx_valid), 32'd0);
    chk("t1_occ", 32'(occupancy), 32'd0);
    chk("t1_ovf", 32'(overflow), 32'd0);
    q.delete();
    ovf_m = 1'b0;
    @(posedge clk); #3 arst_n = 1'b1;
    idle(4, 1'b1);

    // Full with simultaneous push and pop
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, mk(i), 1'b0);
    last = mk(8'hEE);
    cycle(1'b1, last, 1'b1);
    chk("t5_occ", 32'(occupancy), 32'(DEPTH));
    chk("t5_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, '0, 1'b1);
    chk("t5_last", 32'(pkt_to_tx), 32'(last));
    idle(2, 1'b1);

    // Wrap-around with random tx_ready
    base = n_popped; sent = 0; guard = 0;
    while (sent < 40 && guard < 2000) begin
      if (q.size() < DEPTH && $urandom_range(0, 3) != 0) begin
        sent++;
        cycle(1'b1, mk(sent), 1'($urandom_range(0, 1)));
      end else begin
        cycle(1'b0, '0, 1'($urandom_range(0, 1)));
      end
      guard++;
    end
    while (q.size() != 0 && guard < 4000) begin
      cycle(1'b0, '0, 1'($urandom_range(0, 1)));
      guard++;
    end
    idle(2, 1'b1);
    chk("t6_sent", 32'(sent), 32'd40);
    chk("t6_received", 32'(n_popped - base), 32'd40);
    chk("t6_occ", 32'(occupancy), 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
